matlu_seq: RTL and testbench
============================

Name: matlu_seq

Overview:
- Parametrised successor to the fixed 2x2 64-bit LU block.
- Sequential Doolittle LU decomposition of an N x N signed fixed-point matrix, without pivoting, using one divider and one multiply-subtract unit time-shared over an in-place working array.
- Start/busy/done handshake and singular-pivot detection.
- Sits in the matrix-math datapath between the matrix loader and the forward/back-substitution stage.

Parameters:
- N, 4, matrix dimension (2..8).
- W, 32, element width, two's complement.
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC). FRAC=0 gives pure integer mode.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request decomposition; sampled only in IDLE.
- a, input, N*N*W, input matrix. Element (r,c) is at bits [(r*N+c)*W +: W], so (0,0) is at the LSBs.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the result (or singular abort) is final.
- singular, output, 1, set with done if a zero pivot was found; held until next accepted start.
- ll, output, N*N*W, lower factor, same packing as a. Unit diagonal = 1<<FRAC; entries above the diagonal = 0.
- uu, output, N*N*W, upper factor, same packing. Entries below the diagonal = 0.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, singular=0; ll=0, uu=0; working array and all counters cleared. Reset asserted mid-operation aborts immediately, with no done pulse.
- States:
  - IDLE: start=1 loads a into the working array, sets L = identity(1<<FRAC), clears singular, k=0, goes to PIVOT. start is ignored in all other states.
  - PIVOT: if U[k][k]==0, set singular=1 and go to FIN. Else if k==N-1, go to FIN. Else i=k+1, go to DIV.
  - DIV: L[i][k] = low W bits of ((sign-extended U[i][k]) << FRAC) / U[k][k]. Division is signed and truncates toward zero. Set U[i][k]=0, j=k+1. Go to UPD, or to the next row if k==N-1.
  - UPD: U[i][j] = U[i][j] - low W bits of ((L[i][k]*U[k][j]) >>> FRAC), using the full 2W-bit signed product with an arithmetic shift. Subtraction is modulo 2^W; there is no saturation. Increment j. After j==N-1, increment i; after i==N-1, increment k and go to PIVOT.
  - FIN: drive ll/uu from the working array, pulse done=1 for one cycle, busy=0, return to IDLE.
- Latency (start-sample edge to done-high edge): L = 1 + sum over k=0..N-1 of (1 + m_k*(1+m_k)), where m_k = N-1-k.
  - N=2: L=5.
  - N=4: L=25.
- Singular abort at step k: L = 1 + sum over j<k of (1 + m_j*(1+m_j)) + 1.
- ll/uu update only on the done cycle and otherwise hold the previous result. On singular abort they show the partial working array; the contents are defined, but only informative.
- start held high through done: a new decomposition starts on the first IDLE cycle after done. A start in the same cycle as done is ignored.
- Input a is sampled only at the load edge; later changes to a have no effect.

Test Plan:
- N=2, W=64, FRAC=0, a={(0,0)=4,(0,1)=2,(1,0)=8,(1,1)=8}, start pulse -> done exactly 5 cycles later; ll={1,0,2,1}, uu={4,2,0,4}; singular=0.
- Same config, a={2,4,6,8} -> ll={1,0,3,1}, uu={2,4,0,-4} (0xFFFF_FFFF_FFFF_FFFC).
- Same config, a={0,1,1,1} -> done 2 cycles after start; singular=1. Then a={4,2,8,8} with start -> singular=0 and correct result.
- N=4, W=32, FRAC=16, a = 2.0*I + 1.0*(ones above the diagonal) -> done at 25 cycles; ll = identity (0x00010000 diagonal); uu == a.
- Reset mid-operation (rst=1 at cycle 3) -> busy/done/ll/uu = 0 immediately. start during busy -> ignored; no extra done.
- Back-to-back: start held high -> second done exactly L+1 cycles after the first done; ll/uu stable between pulses.

Source files
------------

// File: rtl/matlu_seq.sv
// matlu_seq: sequential Doolittle LU decomposition (no pivoting) of an
// N x N signed fixed-point matrix, Q(W-FRAC).FRAC. One divider and one
// multiply-subtract unit are time-shared over an in-place working array.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request decomposition, sampled only in IDLE
//   a        - input matrix, element (r,c) at [(r*N+c)*W +: W]
//   busy     - high while a decomposition is in progress
//   done     - one-cycle pulse when ll/uu (or a singular abort) are final
//   singular - zero pivot found; held until the next accepted start
//   ll, uu   - lower (unit diagonal) and upper factors, same packing as a
module matlu_seq #(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N*W-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             singular,
  output logic [N*N*W-1:0] ll,
  output logic [N*N*W-1:0] uu
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [W-1:0]  ONE_FX = {{(W-1){1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {IDLE, PIVOT, DIV, UPD, FIN} state_t;

  state_t        state;
  logic [IW-1:0] k, i, j;
  logic [W-1:0]  um [N][N];  // working U, updated in place
  logic [W-1:0]  lm [N][N];  // working L

  // Shared arithmetic, operands selected by the current (k,i,j).
  logic signed [2*W-1:0] num, den, mul_a, mul_b, prod;
  logic        [W-1:0]   div_q, sub_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    num   = $signed({{W{um[i][k][W-1]}}, um[i][k]}) <<< FRAC;
    den   = $signed({{W{um[k][k][W-1]}}, um[k][k]});
    // den is never zero in DIV (PIVOT filters it); the guard keeps the idle datapath defined.
    div_q = (den == '0) ? '0 : W'(num / den);
    mul_a = $signed({{W{lm[i][k][W-1]}}, lm[i][k]});
    mul_b = $signed({{W{um[k][j][W-1]}}, um[k][j]});
    prod  = mul_a * mul_b;
    sub_q = W'(prod >>> FRAC);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      singular <= 1'b0;
      ll       <= '0;
      uu       <= '0;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      // NOTE: the working arrays are cleared on reset because the block must
      // come up with fully defined contents, not just defined control state.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          um[r][c] <= '0;
          lm[r][c] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                um[r][c] <= a[(r*N+c)*W +: W];
                lm[r][c] <= (r == c) ? ONE_FX : '0;
              end
            end
            singular <= 1'b0;
            busy     <= 1'b1;
            k        <= '0;
            state    <= PIVOT;
          end
        end
        PIVOT: begin
          if (um[k][k] == '0) begin
            singular <= 1'b1;
            state    <= FIN;
          end else if (k == LAST) begin
            state <= FIN;
          end else begin
            i     <= k + IW'(1);
            state <= DIV;
          end
        end
        DIV: begin
          lm[i][k] <= div_q;
          um[i][k] <= '0;
          j        <= k + IW'(1);
          state    <= UPD;
        end
        UPD: begin
          um[i][j] <= um[i][j] - sub_q;
          if (j == LAST) begin
            if (i == LAST) begin
              k     <= k + IW'(1);
              state <= PIVOT;
            end else begin
              i     <= i + IW'(1);
              state <= DIV;
            end
          end else begin
            j <= j + IW'(1);
          end
        end
        FIN: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              ll[(r*N+c)*W +: W] <= lm[r][c];
              uu[(r*N+c)*W +: W] <= um[r][c];
            end
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matlu_seq.sv
// Directed testbench for matlu_seq: an integer N=2/W=64 instance and a
// Q16.16 N=4/W=32 instance share clock and reset.
module tb_matlu_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start2 = 1'b0;
  logic [255:0] a2 = '0;
  logic         busy2, done2, sing2;
  logic [255:0] ll2, uu2;

  logic         start4 = 1'b0;
  logic [511:0] a4 = '0;
  logic         busy4, done4, sing4;
  logic [511:0] ll4, uu4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matlu_seq #(.N(2), .W(64), .FRAC(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2),
    .busy(busy2), .done(done2), .singular(sing2), .ll(ll2), .uu(uu2)
  );

  matlu_seq #(.N(4), .W(32), .FRAC(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4),
    .busy(busy4), .done(done4), .singular(sing4), .ll(ll4), .uu(uu4)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] p2(input logic [63:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  // Pulse start on dut2; returns #1 after the accepting edge.
  task automatic go2(input logic [255:0] av);
    @(negedge clk);
    a2     = av;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
  endtask

  task automatic go4(input logic [511:0] av);
    @(negedge clk);
    a4     = av;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  // Edges until done is seen (#1 after the edge); -1 on timeout.
  task automatic wait2(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        cyc = n;
        return;
      end
    end
  endtask

  task automatic wait4(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        cyc = n;
        return;
      end
    end
  endtask

  // Watches dut2 for `n` edges; seen=1 if any done pulse appeared.
  task automatic watch2(input int n, output logic seen);
    seen = 1'b0;
    for (int m = 0; m < n; m++) begin
      @(posedge clk);
      #1;
      if (done2) seen = 1'b1;
    end
  endtask

  initial begin
    int           cyc;
    logic         seen;
    logic         stable;
    logic [511:0] exp_l, exp_u;

    // Reset state
    #12;
    check("rst_busy", 512'(busy2), 512'(0));
    check("rst_done", 512'(done2), 512'(0));
    check("rst_sing", 512'(sing2), 512'(0));
    check("rst_ll",   512'(ll2),   512'(0));
    check("rst_uu",   512'(uu4),   512'(0));
    @(negedge clk);
    rst = 1'b0;

    // N=2 integer: {4,2,8,8}
    go2(p2(64'd4, 64'd2, 64'd8, 64'd8));
    check("t1_busy", 512'(busy2), 512'(1));
    wait2(cyc);
    check("t1_lat",  512'(cyc),   512'(5));
    check("t1_ll",   512'(ll2),   512'(p2(64'd1, 64'd0, 64'd2, 64'd1)));
    check("t1_uu",   512'(uu2),   512'(p2(64'd4, 64'd2, 64'd0, 64'd4)));
    check("t1_sing", 512'(sing2), 512'(0));
    check("t1_busy_done", 512'(busy2), 512'(0));
    @(posedge clk);
    #1;
    check("t1_pulse", 512'(done2), 512'(0));

    // N=2 integer: {2,4,6,8}, negative result
    go2(p2(64'd2, 64'd4, 64'd6, 64'd8));
    wait2(cyc);
    check("t2_lat", 512'(cyc), 512'(5));
    check("t2_ll",  512'(ll2), 512'(p2(64'd1, 64'd0, 64'd3, 64'd1)));
    check("t2_uu",  512'(uu2), 512'(p2(64'd2, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC)));

    // Zero pivot at k=0
    go2(p2(64'd0, 64'd1, 64'd1, 64'd1));
    wait2(cyc);
    check("t3_lat",  512'(cyc),   512'(2));
    check("t3_sing", 512'(sing2), 512'(1));
    go2(p2(64'd4, 64'd2, 64'd8, 64'd8));
    check("t3_sing_clr", 512'(sing2), 512'(0));
    wait2(cyc);
    check("t3b_lat", 512'(cyc), 512'(5));
    check("t3b_ll",  512'(ll2), 512'(p2(64'd1, 64'd0, 64'd2, 64'd1)));
    check("t3b_uu",  512'(uu2), 512'(p2(64'd4, 64'd2, 64'd0, 64'd4)));

    // Start during busy is ignored; a change to a after load has no effect
    go2(p2(64'd2, 64'd4, 64'd6, 64'd8));
    @(posedge clk);
    #1;
    start2 = 1'b1;
    a2     = p2(64'd4, 64'd2, 64'd8, 64'd8);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    wait2(cyc);
    check("t4_lat", 512'(cyc + 2), 512'(5));
    check("t4_uu",  512'(uu2), 512'(p2(64'd2, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC)));
    watch2(10, seen);
    check("t4_no_extra", 512'(seen), 512'(0));

    // N=4 Q16.16: 2.0*I + 1.0 above the diagonal -> L=I, U=A
    exp_l = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a4[(r*4+c)*32 +: 32] = (r == c) ? 32'h0002_0000 : (c > r) ? 32'h0001_0000 : 32'h0;
        exp_l[(r*4+c)*32 +: 32] = (r == c) ? 32'h0001_0000 : 32'h0;
      end
    end
    exp_u = a4;
    go4(a4);
    wait4(cyc);
    check("t5_lat",  512'(cyc), 512'(25));
    check("t5_ll",   ll4, exp_l);
    check("t5_uu",   uu4, exp_u);
    check("t5_sing", 512'(sing4), 512'(0));

    // Same plus a(1,0)=1.0: L10=0.5, U row 1 = {0, 1.5, 0.5, 0.5}
    a4[(1*4+0)*32 +: 32]    = 32'h0001_0000;
    exp_l[(1*4+0)*32 +: 32] = 32'h0000_8000;
    exp_u[(1*4+1)*32 +: 32] = 32'h0001_8000;
    exp_u[(1*4+2)*32 +: 32] = 32'h0000_8000;
    exp_u[(1*4+3)*32 +: 32] = 32'h0000_8000;
    go4(a4);
    wait4(cyc);
    check("t6_lat", 512'(cyc), 512'(25));
    check("t6_ll",  ll4, exp_l);
    check("t6_uu",  uu4, exp_u);

    // Reset mid-operation on dut2 (outputs currently nonzero)
    go2(p2(64'd4, 64'd2, 64'd8, 64'd8));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t7_busy", 512'(busy2), 512'(0));
    check("t7_done", 512'(done2), 512'(0));
    check("t7_ll",   512'(ll2),   512'(0));
    check("t7_uu",   512'(uu2),   512'(0));
    @(negedge clk);
    rst = 1'b0;
    watch2(10, seen);
    check("t7_no_done", 512'(seen), 512'(0));

    // Back-to-back with start held high
    @(negedge clk);
    a2     = p2(64'd2, 64'd4, 64'd6, 64'd8);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    wait2(cyc);
    check("t8_lat1", 512'(cyc), 512'(5));
    stable = 1'b1;
    cyc    = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (ll2 !== p2(64'd1, 64'd0, 64'd3, 64'd1) ||
          uu2 !== p2(64'd2, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC)) stable = 1'b0;
      if (done2) begin
        cyc = n;
        break;
      end
    end
    @(negedge clk);
    start2 = 1'b0;
    check("t8_lat2",   512'(cyc),    512'(6));
    check("t8_stable", 512'(stable), 512'(1));
    watch2(10, seen);
    check("t8_no_third", 512'(seen), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
